// File: rtl/creg_host_bridge_if.sv
// Host-side request/response channel of the control-register host bridge.
// The host drives the master modport; the bridge consumes the slave modport.
interface creg_host_bridge_if #(
    parameter int THREAD_W = 2,
    parameter int INDEX_W  = 5,
    parameter int DATA_W   = 32
);
    logic                host_req_valid;
    logic                host_req_ready;
    logic                host_req_write;
    logic [INDEX_W-1:0]  host_req_index;
    logic [THREAD_W-1:0] host_req_thread;
    logic [DATA_W-1:0]   host_req_wdata;
    logic                host_rsp_valid;
    logic                host_rsp_ready;
    logic                host_rsp_write;
    logic [DATA_W-1:0]   host_rsp_rdata;

    modport master (
        output host_req_valid, host_req_write, host_req_index, host_req_thread,
               host_req_wdata, host_rsp_ready,
        input  host_req_ready, host_rsp_valid, host_rsp_write, host_rsp_rdata
    );

    modport slave (
        input  host_req_valid, host_req_write, host_req_index, host_req_thread,
               host_req_wdata, host_rsp_ready,
        output host_req_ready, host_rsp_valid, host_rsp_write, host_rsp_rdata
    );
endinterface

// File: rtl/creg_host_bridge.sv
// Merges host/debug control-register accesses with pipeline accesses onto the
// single creg port; the pipeline always wins and a starved host raises a stall.
module creg_host_bridge #(
    parameter int STARVE_LIMIT = 8,
    parameter int THREAD_W     = 2,
    parameter int INDEX_W      = 5,
    parameter int DATA_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    creg_host_bridge_if.slave   host,
    input  logic [THREAD_W-1:0] dt_thread_idx,
    input  logic                dd_creg_write_en,
    input  logic                dd_creg_read_en,
    input  logic [INDEX_W-1:0]  dd_creg_index,
    input  logic [DATA_W-1:0]   dd_creg_write_val,
    output logic [THREAD_W-1:0] hb_thread_idx,
    output logic                hb_creg_write_en,
    output logic                hb_creg_read_en,
    output logic [INDEX_W-1:0]  hb_creg_index,
    output logic [DATA_W-1:0]   hb_creg_write_val,
    input  logic [DATA_W-1:0]   cr_creg_read_val,
    output logic                hb_stall_request
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PENDING   = 2'd1,
        READ_WAIT = 2'd2,
        RESPOND   = 2'd3
    } state_t;

    localparam logic [7:0] STARVE_THRESH = 8'(STARVE_LIMIT - 1);
    localparam logic [7:0] CNT_MAX       = 8'd255;

    state_t              state_r, state_s;
    logic                req_write_r, req_write_s;
    logic [INDEX_W-1:0]  req_index_r, req_index_s;
    logic [THREAD_W-1:0] req_thread_r, req_thread_s;
    logic [DATA_W-1:0]   req_wdata_r, req_wdata_s;
    logic [7:0]          starve_cnt_r, starve_cnt_s;
    logic                stall_r, stall_s;
    logic [DATA_W-1:0]   rsp_rdata_r, rsp_rdata_s;
    logic                rsp_write_r, rsp_write_s;
    logic                pipe_busy_s;

    assign pipe_busy_s         = dd_creg_write_en | dd_creg_read_en;
    assign host.host_req_ready = (state_r == IDLE);
    assign host.host_rsp_valid = (state_r == RESPOND);
    assign host.host_rsp_rdata = rsp_rdata_r;
    assign host.host_rsp_write = rsp_write_r;
    assign hb_stall_request    = stall_r;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            req_write_r  <= 1'b0;
            req_index_r  <= '0;
            req_thread_r <= '0;
            req_wdata_r  <= '0;
            starve_cnt_r <= 8'd0;
            stall_r      <= 1'b0;
            rsp_rdata_r  <= '0;
            rsp_write_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            req_write_r  <= req_write_s;
            req_index_r  <= req_index_s;
            req_thread_r <= req_thread_s;
            req_wdata_r  <= req_wdata_s;
            starve_cnt_r <= starve_cnt_s;
            stall_r      <= stall_s;
            rsp_rdata_r  <= rsp_rdata_s;
            rsp_write_r  <= rsp_write_s;
        end
    end

    // Next-state logic: latch, defer, issue, capture, respond.
    always_comb begin
        state_s      = state_r;
        req_write_s  = req_write_r;
        req_index_s  = req_index_r;
        req_thread_s = req_thread_r;
        req_wdata_s  = req_wdata_r;
        starve_cnt_s = starve_cnt_r;
        stall_s      = stall_r;
        rsp_rdata_s  = rsp_rdata_r;
        rsp_write_s  = rsp_write_r;
        case (state_r)
            IDLE: begin
                if (host.host_req_valid) begin
                    req_write_s  = host.host_req_write;
                    req_index_s  = host.host_req_index;
                    req_thread_s = host.host_req_thread;
                    req_wdata_s  = host.host_req_wdata;
                    state_s      = PENDING;
                end else begin
                    state_s = IDLE;
                end
            end
            PENDING: begin
                if (pipe_busy_s) begin
                    if (starve_cnt_r != CNT_MAX) begin
                        starve_cnt_s = starve_cnt_r + 8'd1;
                    end else begin
                        starve_cnt_s = starve_cnt_r;
                    end
                    // Once past the threshold the request stays up until issue.
                    if (starve_cnt_r >= STARVE_THRESH) begin
                        stall_s = 1'b1;
                    end else begin
                        stall_s = stall_r;
                    end
                end else begin
                    starve_cnt_s = 8'd0;
                    stall_s      = 1'b0;
                    if (req_write_r) begin
                        rsp_rdata_s = '0;
                        rsp_write_s = 1'b1;
                        state_s     = RESPOND;
                    end else begin
                        state_s = READ_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                // Read data was registered at the previous edge, so a
                // concurrent pipeline access cannot disturb this capture.
                rsp_rdata_s = cr_creg_read_val;
                rsp_write_s = 1'b0;
                state_s     = RESPOND;
            end
            RESPOND: begin
                if (host.host_rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESPOND;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Creg port mux: pipeline first, then the pending host access.
    always_comb begin
        hb_thread_idx     = dt_thread_idx;
        hb_creg_index     = dd_creg_index;
        hb_creg_write_val = dd_creg_write_val;
        hb_creg_write_en  = 1'b0;
        hb_creg_read_en   = 1'b0;
        if (pipe_busy_s) begin
            hb_creg_write_en = dd_creg_write_en;
            hb_creg_read_en  = dd_creg_read_en;
        end else if (state_r == PENDING) begin
            hb_thread_idx     = req_thread_r;
            hb_creg_index     = req_index_r;
            hb_creg_write_val = req_wdata_r;
            hb_creg_write_en  = req_write_r;
            hb_creg_read_en   = ~req_write_r;
        end else begin
            hb_creg_write_en = 1'b0;
            hb_creg_read_en  = 1'b0;
        end
    end

endmodule

// File: tb/tb_creg_host_bridge.sv
// Directed self-checking bench for creg_host_bridge with a small
// control-register model answering on the merged creg port.
module tb_creg_host_bridge;

    localparam int THREAD_W = 2;
    localparam int INDEX_W  = 5;
    localparam int DATA_W   = 32;

    localparam logic [INDEX_W-1:0] CR_STRAND_ENABLE = 5'd0;
    localparam logic [INDEX_W-1:0] CR_STRAND_ID     = 5'd1;
    localparam logic [INDEX_W-1:0] CR_SCRATCH       = 5'd9;

    logic                clk;
    logic                reset;
    logic [THREAD_W-1:0] dt_thread_idx;
    logic                dd_creg_write_en;
    logic                dd_creg_read_en;
    logic [INDEX_W-1:0]  dd_creg_index;
    logic [DATA_W-1:0]   dd_creg_write_val;
    logic [THREAD_W-1:0] hb_thread_idx;
    logic                hb_creg_write_en;
    logic                hb_creg_read_en;
    logic [INDEX_W-1:0]  hb_creg_index;
    logic [DATA_W-1:0]   hb_creg_write_val;
    logic [DATA_W-1:0]   cr_creg_read_val;
    logic                hb_stall_request;

    logic [DATA_W-1:0]   strand_enable_reg;
    logic [DATA_W-1:0]   scratch_reg;

    int checks = 0;
    int errors = 0;

    creg_host_bridge_if #(.THREAD_W(THREAD_W), .INDEX_W(INDEX_W), .DATA_W(DATA_W)) hif ();

    creg_host_bridge #(
        .STARVE_LIMIT (4),
        .THREAD_W     (THREAD_W),
        .INDEX_W      (INDEX_W),
        .DATA_W       (DATA_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .host              (hif),
        .dt_thread_idx     (dt_thread_idx),
        .dd_creg_write_en  (dd_creg_write_en),
        .dd_creg_read_en   (dd_creg_read_en),
        .dd_creg_index     (dd_creg_index),
        .dd_creg_write_val (dd_creg_write_val),
        .hb_thread_idx     (hb_thread_idx),
        .hb_creg_write_en  (hb_creg_write_en),
        .hb_creg_read_en   (hb_creg_read_en),
        .hb_creg_index     (hb_creg_index),
        .hb_creg_write_val (hb_creg_write_val),
        .cr_creg_read_val  (cr_creg_read_val),
        .hb_stall_request  (hb_stall_request)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control-register model: registered read data, one cycle after read_en.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            strand_enable_reg <= 32'd0;
            scratch_reg       <= 32'd0;
            cr_creg_read_val  <= 32'd0;
        end else begin
            if (hb_creg_write_en) begin
                case (hb_creg_index)
                    CR_STRAND_ENABLE: strand_enable_reg <= hb_creg_write_val;
                    CR_SCRATCH:       scratch_reg       <= hb_creg_write_val;
                    default:          ;
                endcase
            end
            if (hb_creg_read_en) begin
                case (hb_creg_index)
                    CR_STRAND_ENABLE: cr_creg_read_val <= strand_enable_reg;
                    CR_STRAND_ID:     cr_creg_read_val <= {30'd0, hb_thread_idx};
                    CR_SCRATCH:       cr_creg_read_val <= scratch_reg;
                    default:          cr_creg_read_val <= 32'd0;
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic host_req(input logic wr, input logic [INDEX_W-1:0] idx,
                            input logic [THREAD_W-1:0] thr, input logic [DATA_W-1:0] wd);
        hif.host_req_valid  = 1'b1;
        hif.host_req_write  = wr;
        hif.host_req_index  = idx;
        hif.host_req_thread = thr;
        hif.host_req_wdata  = wd;
    endtask

    initial begin
        reset                = 1'b0;
        hif.host_req_valid   = 1'b0;
        hif.host_req_write   = 1'b0;
        hif.host_req_index   = '0;
        hif.host_req_thread  = '0;
        hif.host_req_wdata   = '0;
        hif.host_rsp_ready   = 1'b1;
        dt_thread_idx        = '0;
        dd_creg_write_en     = 1'b0;
        dd_creg_read_en      = 1'b0;
        dd_creg_index        = '0;
        dd_creg_write_val    = '0;

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", 32'(hif.host_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(hif.host_rsp_valid), 32'd0);
        chk("rst_rsp_rdata", hif.host_rsp_rdata, 32'd0);
        chk("rst_rsp_write", 32'(hif.host_rsp_write), 32'd0);
        chk("rst_stall", 32'(hb_stall_request), 32'd0);
        chk("rst_rd_en", 32'(hb_creg_read_en), 32'd0);
        step();
        reset = 1'b1;
        step();

        // Test 1: host read of strand ID on thread 2, no conflict
        host_req(1'b0, CR_STRAND_ID, 2'd2, 32'd0);
        #1 chk("t1_ready_idle", 32'(hif.host_req_ready), 32'd1);
        step();
        hif.host_req_valid = 1'b0;
        chk("t1_rd_en", 32'(hb_creg_read_en), 32'd1);
        chk("t1_wr_en", 32'(hb_creg_write_en), 32'd0);
        chk("t1_thread", 32'(hb_thread_idx), 32'd2);
        chk("t1_index", 32'(hb_creg_index), 32'(CR_STRAND_ID));
        chk("t1_ready_busy", 32'(hif.host_req_ready), 32'd0);
        step();
        chk("t1_rd_en_pulse", 32'(hb_creg_read_en), 32'd0);
        chk("t1_rsp_early", 32'(hif.host_rsp_valid), 32'd0);
        step();
        chk("t1_rsp_valid", 32'(hif.host_rsp_valid), 32'd1);
        chk("t1_rsp_rdata", hif.host_rsp_rdata, 32'd2);
        chk("t1_rsp_write", 32'(hif.host_rsp_write), 32'd0);
        step();
        chk("t1_rsp_done", 32'(hif.host_rsp_valid), 32'd0);
        chk("t1_ready_again", 32'(hif.host_req_ready), 32'd1);

        // Test 2: host write of 0xF to strand enable
        host_req(1'b1, CR_STRAND_ENABLE, 2'd0, 32'h0000_000F);
        step();
        hif.host_req_valid = 1'b0;
        chk("t2_wr_en", 32'(hb_creg_write_en), 32'd1);
        chk("t2_wr_val", hb_creg_write_val, 32'h0000_000F);
        chk("t2_rd_en", 32'(hb_creg_read_en), 32'd0);
        step();
        chk("t2_wr_pulse", 32'(hb_creg_write_en), 32'd0);
        chk("t2_rsp_valid", 32'(hif.host_rsp_valid), 32'd1);
        chk("t2_rsp_rdata", hif.host_rsp_rdata, 32'd0);
        chk("t2_rsp_write", 32'(hif.host_rsp_write), 32'd1);
        chk("t2_strand_en", strand_enable_reg, 32'h0000_000F);
        step();

        // Test 3: pipeline write blocks a pending host read for 3 cycles
        host_req(1'b0, CR_STRAND_ENABLE, 2'd0, 32'd0);
        dd_creg_write_en  = 1'b1;
        dd_creg_index     = CR_SCRATCH;
        dd_creg_write_val = 32'h0000_1234;
        dt_thread_idx     = 2'd1;
        step();
        hif.host_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_pass_wr_en", 32'(hb_creg_write_en), 32'd1);
            chk("t3_pass_rd_en", 32'(hb_creg_read_en), 32'd0);
            chk("t3_pass_index", 32'(hb_creg_index), 32'(CR_SCRATCH));
            chk("t3_pass_val", hb_creg_write_val, 32'h0000_1234);
            chk("t3_pass_thread", 32'(hb_thread_idx), 32'd1);
            step();
        end
        dd_creg_write_en = 1'b0;
        #1;
        chk("t3_issue_rd_en", 32'(hb_creg_read_en), 32'd1);
        chk("t3_issue_index", 32'(hb_creg_index), 32'(CR_STRAND_ENABLE));
        chk("t3_issue_thread", 32'(hb_thread_idx), 32'd0);
        step();
        // Pipeline read during READ_WAIT must not corrupt the capture
        dd_creg_read_en = 1'b1;
        dd_creg_index   = CR_STRAND_ID;
        dt_thread_idx   = 2'd3;
        #1;
        chk("t3_rw_pass_rd", 32'(hb_creg_read_en), 32'd1);
        chk("t3_rw_pass_idx", 32'(hb_creg_index), 32'(CR_STRAND_ID));
        step();
        dd_creg_read_en = 1'b0;
        chk("t3_rsp_valid", 32'(hif.host_rsp_valid), 32'd1);
        chk("t3_rsp_rdata", hif.host_rsp_rdata, 32'h0000_000F);
        chk("t3_rsp_write", 32'(hif.host_rsp_write), 32'd0);
        chk("t3_no_stall", 32'(hb_stall_request), 32'd0);
        chk("t3_scratch", scratch_reg, 32'h0000_1234);
        step();

        // Test 4: continuous pipeline traffic starves the host (limit 4)
        host_req(1'b1, CR_SCRATCH, 2'd1, 32'h0000_00A5);
        dd_creg_read_en = 1'b1;
        dd_creg_index   = CR_STRAND_ID;
        dt_thread_idx   = 2'd3;
        step();
        hif.host_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t4_stall_low", 32'(hb_stall_request), 32'd0);
            chk("t4_host_held", 32'(hb_creg_write_en), 32'd0);
            step();
        end
        chk("t4_stall_high", 32'(hb_stall_request), 32'd1);
        dd_creg_read_en = 1'b0;
        #1;
        chk("t4_issue_wr_en", 32'(hb_creg_write_en), 32'd1);
        chk("t4_issue_val", hb_creg_write_val, 32'h0000_00A5);
        chk("t4_issue_index", 32'(hb_creg_index), 32'(CR_SCRATCH));
        step();
        chk("t4_stall_clear", 32'(hb_stall_request), 32'd0);
        chk("t4_rsp_valid", 32'(hif.host_rsp_valid), 32'd1);
        chk("t4_rsp_write", 32'(hif.host_rsp_write), 32'd1);
        chk("t4_rsp_rdata", hif.host_rsp_rdata, 32'd0);
        chk("t4_scratch", scratch_reg, 32'h0000_00A5);
        step();

        // Test 5: response back-pressure for 5 cycles
        hif.host_rsp_ready = 1'b0;
        host_req(1'b0, CR_STRAND_ID, 2'd1, 32'd0);
        step();
        hif.host_req_valid = 1'b0;
        step();
        step();
        chk("t5_rsp_valid", 32'(hif.host_rsp_valid), 32'd1);
        chk("t5_rsp_rdata", hif.host_rsp_rdata, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_hold_valid", 32'(hif.host_rsp_valid), 32'd1);
            chk("t5_hold_rdata", hif.host_rsp_rdata, 32'd1);
            chk("t5_hold_write", 32'(hif.host_rsp_write), 32'd0);
            chk("t5_hold_ready", 32'(hif.host_req_ready), 32'd0);
        end
        hif.host_rsp_ready = 1'b1;
        #1 chk("t5_hs_ready_low", 32'(hif.host_req_ready), 32'd0);
        step();
        chk("t5_post_valid", 32'(hif.host_rsp_valid), 32'd0);
        chk("t5_post_ready", 32'(hif.host_req_ready), 32'd1);

        // Test 6: reset asserted during READ_WAIT abandons the transaction
        host_req(1'b0, CR_STRAND_ENABLE, 2'd0, 32'd0);
        step();
        hif.host_req_valid = 1'b0;
        step();
        chk("t6_in_readwait", 32'(hif.host_req_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(hif.host_rsp_valid), 32'd0);
        chk("t6_rst_ready", 32'(hif.host_req_ready), 32'd1);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_no_rd_en", 32'(hb_creg_read_en), 32'd0);
            chk("t6_no_wr_en", 32'(hb_creg_write_en), 32'd0);
            chk("t6_no_rsp", 32'(hif.host_rsp_valid), 32'd0);
            chk("t6_ready", 32'(hif.host_req_ready), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
